// File: rtl/traffic_generator.sv
// Memory traffic generator: after controller init/calibration it writes an
// address-derived pattern to 0..LAST_ADDR, then reads the same range back once.
module traffic_generator #(
  parameter logic [24:0] LAST_ADDR = 25'h1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ddr3_init_done,
  input  logic        ddr3_cal_success,
  input  logic        ddr3_cal_fail,
  input  logic        avl_ready,
  output logic        avl_burstbegin,
  output logic        avl_write_req,
  output logic        avl_read_req,
  output logic [24:0] avl_addr,
  output logic [63:0] avl_wdata,
  output logic [7:0]  avl_be,
  output logic [2:0]  avl_size,
  output logic        is_finished,
  output logic        fail
);

  localparam logic [2:0] WAIT_FOR_INIT = 3'd0;
  localparam logic [2:0] WRITE         = 3'd1;
  localparam logic [2:0] READ          = 3'd2;
  localparam logic [2:0] DONE          = 3'd3;
  localparam logic [2:0] ERROR         = 3'd4;

  localparam logic [63:0] WDATA_SEED = 64'hdeadfadebabebeef;

  logic [2:0]  r_state;
  logic [24:0] r_addr_counter;
  logic        r_is_finished;
  logic        r_fail;

  logic [2:0]  w_state_nxt;
  logic [24:0] w_addr_nxt;
  logic        w_at_last;

  assign w_at_last = (r_addr_counter == LAST_ADDR);

  // Requests advance only on an accepted edge, so a stalled request holds
  // its address and data without any extra skid storage.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr_counter;
    case (r_state)
      WAIT_FOR_INIT: begin
        if (ddr3_init_done) begin
          if (ddr3_cal_success)   w_state_nxt = WRITE;
          else if (ddr3_cal_fail) w_state_nxt = ERROR;
        end
      end
      WRITE: begin
        if (avl_ready) begin
          if (w_at_last) begin
            w_addr_nxt  = 25'd0;
            w_state_nxt = READ;
          end else begin
            w_addr_nxt  = r_addr_counter + 25'd1;
          end
        end
      end
      READ: begin
        if (avl_ready) begin
          if (w_at_last) w_state_nxt = DONE;
          else           w_addr_nxt  = r_addr_counter + 25'd1;
        end
      end
      DONE:    w_state_nxt = DONE;
      ERROR:   w_state_nxt = ERROR;
      default: w_state_nxt = WAIT_FOR_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= WAIT_FOR_INIT;
      r_addr_counter <= 25'd0;
      r_is_finished  <= 1'b0;
      r_fail         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr_counter <= w_addr_nxt;
      r_is_finished  <= (r_state == DONE) || (r_state == ERROR);
      r_fail         <= (r_state == ERROR);
    end
  end

  // All request outputs are decoded purely from registered state.
  assign avl_write_req  = (r_state == WRITE);
  assign avl_read_req   = (r_state == READ);
  assign avl_burstbegin = avl_write_req | avl_read_req;
  assign avl_addr       = r_addr_counter;
  assign avl_wdata      = WDATA_SEED ^ {39'h0, r_addr_counter};
  assign avl_be         = 8'hff;
  assign avl_size       = 3'h1;
  assign is_finished    = r_is_finished;
  assign fail           = r_fail;

endmodule

// File: tb/tb_traffic_generator.sv
// Directed bench for traffic_generator with LAST_ADDR=3.
module tb_traffic_generator;

  localparam logic [63:0] SEED = 64'hdeadfadebabebeef;

  logic        clk;
  logic        reset_n;
  logic        ddr3_init_done;
  logic        ddr3_cal_success;
  logic        ddr3_cal_fail;
  logic        avl_ready;
  logic        avl_burstbegin;
  logic        avl_write_req;
  logic        avl_read_req;
  logic [24:0] avl_addr;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic [2:0]  avl_size;
  logic        is_finished;
  logic        fail;

  int errors = 0;
  int checks = 0;

  traffic_generator #(.LAST_ADDR(25'd3)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ddr3_init_done   (ddr3_init_done),
    .ddr3_cal_success (ddr3_cal_success),
    .ddr3_cal_fail    (ddr3_cal_fail),
    .avl_ready        (avl_ready),
    .avl_burstbegin   (avl_burstbegin),
    .avl_write_req    (avl_write_req),
    .avl_read_req     (avl_read_req),
    .avl_addr         (avl_addr),
    .avl_wdata        (avl_wdata),
    .avl_be           (avl_be),
    .avl_size         (avl_size),
    .is_finished      (is_finished),
    .fail             (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n          = 1'b0;
    ddr3_init_done   = 1'b0;
    ddr3_cal_success = 1'b0;
    ddr3_cal_fail    = 1'b0;
    avl_ready        = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_ok();
    @(negedge clk);
    ddr3_init_done   = 1'b1;
    ddr3_cal_success = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    avl_ready = 1'b1;
    #3;
    checks++;
    if ({avl_write_req, avl_read_req, avl_burstbegin, is_finished, fail} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {avl_write_req, avl_read_req, avl_burstbegin, is_finished, fail});
    end
    checks++;
    if (avl_addr !== 25'd0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", avl_addr);
    end
    checks++;
    if (avl_wdata !== SEED) begin
      errors++; $display("FAIL reset_wdata: got %h want %h", avl_wdata, SEED);
    end
    checks++;
    if (avl_be !== 8'hff || avl_size !== 3'h1) begin
      errors++; $display("FAIL reset_be_size: got %h/%h want ff/1", avl_be, avl_size);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // Status inputs without init_done must be ignored.
    ddr3_cal_success = 1'b1;
    ddr3_cal_fail    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (avl_burstbegin !== 1'b0 || is_finished !== 1'b0) begin
      errors++;
      $display("FAIL ignore_status: got bb=%b fin=%b want 0/0", avl_burstbegin, is_finished);
    end
  endtask

  task automatic test_normal();
    do_reset();
    repeat (4) @(negedge clk);
    start_ok();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (avl_write_req !== 1'b1 || avl_read_req !== 1'b0 || avl_burstbegin !== 1'b1) begin
        errors++;
        $display("FAIL write_req[%0d]: got w=%b r=%b bb=%b want 1/0/1",
                 i, avl_write_req, avl_read_req, avl_burstbegin);
      end
      checks++;
      if (avl_addr !== 25'(i) || avl_wdata !== (SEED ^ 64'(i))) begin
        errors++;
        $display("FAIL write_addr_data[%0d]: got %h/%h want %h/%h",
                 i, avl_addr, avl_wdata, 25'(i), SEED ^ 64'(i));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (avl_read_req !== 1'b1 || avl_write_req !== 1'b0 || avl_addr !== 25'(i)) begin
        errors++;
        $display("FAIL read[%0d]: got r=%b w=%b addr=%h want 1/0/%h",
                 i, avl_read_req, avl_write_req, avl_addr, 25'(i));
      end
      @(negedge clk);
    end
    checks++;
    if (avl_burstbegin !== 1'b0 || is_finished !== 1'b0) begin
      errors++;
      $display("FAIL done_entry: got bb=%b fin=%b want 0/0", avl_burstbegin, is_finished);
    end
    checks++;
    if (avl_addr !== 25'd3) begin
      errors++; $display("FAIL done_addr_hold: got %h want 3", avl_addr);
    end
    @(negedge clk);
    checks++;
    if (is_finished !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL done_flags: got fin=%b fail=%b want 1/0", is_finished, fail);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (avl_burstbegin !== 1'b0 || is_finished !== 1'b1 || avl_addr !== 25'd3) begin
      errors++;
      $display("FAIL done_terminal: got bb=%b fin=%b addr=%h want 0/1/3",
               avl_burstbegin, is_finished, avl_addr);
    end
  endtask

  task automatic test_error();
    int reqs;
    reqs = 0;
    do_reset();
    @(negedge clk);
    ddr3_init_done = 1'b1;
    ddr3_cal_fail  = 1'b1;
    @(negedge clk);
    if (avl_burstbegin) reqs++;
    checks++;
    if (is_finished !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL error_entry: got fin=%b fail=%b want 0/0", is_finished, fail);
    end
    @(negedge clk);
    if (avl_burstbegin) reqs++;
    checks++;
    if (is_finished !== 1'b1 || fail !== 1'b1) begin
      errors++; $display("FAIL error_flags: got fin=%b fail=%b want 1/1", is_finished, fail);
    end
    ddr3_cal_success = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (avl_burstbegin || avl_write_req || avl_read_req) reqs++;
    end
    checks++;
    if (reqs !== 0 || fail !== 1'b1) begin
      errors++; $display("FAIL error_no_traffic: got reqs=%0d fail=%b want 0/1", reqs, fail);
    end
  endtask

  task automatic test_both_status();
    do_reset();
    @(negedge clk);
    ddr3_init_done   = 1'b1;
    ddr3_cal_success = 1'b1;
    ddr3_cal_fail    = 1'b1;
    @(negedge clk);
    checks++;
    if (avl_write_req !== 1'b1 || avl_addr !== 25'd0) begin
      errors++;
      $display("FAIL both_status_write: got w=%b addr=%h want 1/0", avl_write_req, avl_addr);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (fail !== 1'b0 || is_finished !== 1'b1) begin
      errors++; $display("FAIL both_status_flags: got fail=%b fin=%b want 0/1", fail, is_finished);
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_ok();
    repeat (2) @(negedge clk);
    checks++;
    if (avl_addr !== 25'd2 || avl_write_req !== 1'b1) begin
      errors++; $display("FAIL stall_pre: got addr=%h w=%b want 2/1", avl_addr, avl_write_req);
    end
    avl_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (avl_write_req !== 1'b1 || avl_addr !== 25'd2 || avl_wdata !== (SEED ^ 64'd2)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got w=%b addr=%h data=%h want 1/2/%h",
                 k, avl_write_req, avl_addr, avl_wdata, SEED ^ 64'd2);
      end
    end
    avl_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (avl_write_req !== 1'b1 || avl_addr !== 25'd3) begin
      errors++;
      $display("FAIL stall_single_write: got w=%b addr=%h want 1/3", avl_write_req, avl_addr);
    end
    @(negedge clk);
    checks++;
    if (avl_read_req !== 1'b1 || avl_addr !== 25'd0) begin
      errors++;
      $display("FAIL stall_turnaround: got r=%b addr=%h want 1/0", avl_read_req, avl_addr);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    start_ok();
    repeat (5) @(negedge clk);
    checks++;
    if (avl_read_req !== 1'b1 || avl_addr !== 25'd1) begin
      errors++; $display("FAIL mid_read_pre: got r=%b addr=%h want 1/1", avl_read_req, avl_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (avl_read_req !== 1'b0 || avl_burstbegin !== 1'b0 || avl_addr !== 25'd0) begin
      errors++;
      $display("FAIL mid_read_async: got r=%b bb=%b addr=%h want 0/0/0",
               avl_read_req, avl_burstbegin, avl_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (avl_burstbegin !== 1'b0) begin
      errors++; $display("FAIL mid_read_wait: got bb=%b want 0", avl_burstbegin);
    end
    @(negedge clk);
    checks++;
    if (avl_write_req !== 1'b1 || avl_addr !== 25'd0 || avl_wdata !== SEED) begin
      errors++;
      $display("FAIL mid_read_replay: got w=%b addr=%h data=%h want 1/0/%h",
               avl_write_req, avl_addr, avl_wdata, SEED);
    end
  endtask

  // Receiver-side read checker: reads must be 0..3 in order, with no gap
  // between the final write and the first read.
  task automatic test_back_to_back();
    int exp_rd, order_err, cycles;
    logic prev_last_wr;
    exp_rd = 0; order_err = 0; cycles = 0; prev_last_wr = 1'b0;
    do_reset();
    start_ok();
    while (!is_finished && cycles < 40) begin
      if (avl_read_req) begin
        if (avl_addr !== 25'(exp_rd)) order_err++;
        if (exp_rd == 0 && !prev_last_wr) order_err++;
        exp_rd++;
      end
      prev_last_wr = avl_write_req && (avl_addr == 25'd3);
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles >= 40) begin
      errors++; $display("FAIL b2b_timeout: got %0d cycles want <40", cycles);
    end
    checks++;
    if (exp_rd !== 4 || order_err !== 0) begin
      errors++; $display("FAIL b2b_checker: got reads=%0d errs=%0d want 4/0", exp_rd, order_err);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++; $display("FAIL b2b_fail_flag: got %b want 0", fail);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_error();
    test_both_status();
    test_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
